// File: rtl/quad_seven_seg_rx.sv
// Receive side of a quad multiplexed 7-segment display: synchronises the anode/cathode
// lines, captures each digit after a stable dwell and publishes coherent 4-digit frames.
module quad_seven_seg_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       an3,
    input  logic       an2,
    input  logic       an1,
    input  logic       an0,
    input  logic       ca,
    input  logic       cb,
    input  logic       cc,
    input  logic       cd,
    input  logic       ce,
    input  logic       cf,
    input  logic       cg,
    input  logic       dp,
    output logic [3:0] val3,
    output logic [3:0] val2,
    output logic [3:0] val1,
    output logic [3:0] val0,
    output logic       dot3,
    output logic       dot2,
    output logic       dot1,
    output logic       dot0,
    output logic       digit_strobe,
    output logic [1:0] digit_idx,
    output logic       seg_err,
    output logic       frame_valid,
    output logic       frame_err
);

    logic [11:0]      raw;
    logic [11:0]      sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             single;
    logic [1:0]       idx;
    logic             stable;
    logic             capture;
    logic [3:0]       dec_val;
    logic             dec_ok;
    logic             dec_dot;
    logic [3:0]       cap_bit;
    logic [3:0]       mask_q, mask_d;
    logic             err_q;
    logic             frame_done;
    logic [3:0]       shadow_val_q [4];
    logic             shadow_dot_q [4];
    logic [3:0]       merged_val   [4];
    logic             merged_dot   [4];
    logic [3:0]       out_val_q    [4];
    logic             out_dot_q    [4];
    logic             strobe_q, seg_err_q, frame_valid_q, frame_err_q;
    logic [1:0]       idx_q;

    assign raw = {an3, an2, an1, an0, ca, cb, cc, cd, ce, cf, cg, dp};

    always_comb begin
        single = 1'b1;
        idx    = 2'd0;
        case (sync2_q[11:8])
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: single = 1'b0;
        endcase
    end

    // Counter saturates at STABLE_CYCLES so a long dwell captures exactly once.
    assign stable  = (sync2_q == prev_q) && single;
    assign capture = stable && (cnt_q == CNT_W'(STABLE_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!stable)
            cnt_d = '0;
        else if (cnt_q != CNT_W'(STABLE_CYCLES))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (sync2_q[7:1])
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    assign dec_dot    = ~sync2_q[0];
    assign cap_bit    = 4'b0001 << idx;
    assign frame_done = capture && ((mask_q | cap_bit) == 4'b1111);

    always_comb begin
        mask_d = mask_q;
        if (frame_done)
            mask_d = 4'b0000;
        else if (capture)
            mask_d = mask_q | cap_bit;
    end

    // The snapshot must include the digit captured on the completing edge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged_val[gi] = (capture && idx == 2'(gi) && dec_ok) ? dec_val : shadow_val_q[gi];
        assign merged_dot[gi] = (capture && idx == 2'(gi)) ? dec_dot : shadow_dot_q[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            cnt_q         <= '0;
            mask_q        <= '0;
            err_q         <= 1'b0;
            strobe_q      <= 1'b0;
            idx_q         <= 2'd0;
            seg_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_val_q[i] <= 4'h0;
                shadow_dot_q[i] <= 1'b0;
                out_val_q[i]    <= 4'h0;
                out_dot_q[i]    <= 1'b0;
            end
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            err_q         <= frame_done ? 1'b0 : (err_q || (capture && !dec_ok));
            strobe_q      <= capture;
            seg_err_q     <= capture && !dec_ok;
            frame_valid_q <= frame_done;
            frame_err_q   <= frame_done && (err_q || !dec_ok);
            if (capture)
                idx_q <= idx;
            for (int i = 0; i < 4; i++) begin
                shadow_val_q[i] <= merged_val[i];
                shadow_dot_q[i] <= merged_dot[i];
                if (frame_done) begin
                    out_val_q[i] <= merged_val[i];
                    out_dot_q[i] <= merged_dot[i];
                end
            end
        end
    end

    assign val0         = out_val_q[0];
    assign val1         = out_val_q[1];
    assign val2         = out_val_q[2];
    assign val3         = out_val_q[3];
    assign dot0         = out_dot_q[0];
    assign dot1         = out_dot_q[1];
    assign dot2         = out_dot_q[2];
    assign dot3         = out_dot_q[3];
    assign digit_strobe = strobe_q;
    assign digit_idx    = idx_q;
    assign seg_err      = seg_err_q;
    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_quad_seven_seg_rx.sv
// Bench for quad_seven_seg_rx: directed display dwells followed by random ones, each
// checked against a digit/frame model built from the decode table and capture rules.
module tb_quad_seven_seg_rx;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       an3, an2, an1, an0;
    logic       ca, cb, cc, cd, ce, cf, cg, dp;
    logic [3:0] val3, val2, val1, val0;
    logic       dot3, dot2, dot1, dot0;
    logic       digit_strobe, seg_err, frame_valid, frame_err;
    logic [1:0] digit_idx;

    int vectors = 0;
    int miscompares = 0;

    quad_seven_seg_rx #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst),
        .an3(an3), .an2(an2), .an1(an1), .an0(an0),
        .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg), .dp(dp),
        .val3(val3), .val2(val2), .val1(val1), .val0(val0),
        .dot3(dot3), .dot2(dot2), .dot1(dot1), .dot0(dot0),
        .digit_strobe(digit_strobe), .digit_idx(digit_idx), .seg_err(seg_err),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Event monitor: counts cycles each pulse is high, so a count of 1 per event also
    // confirms single-cycle width.
    int         mon_strobes = 0, mon_segerr = 0, mon_fv = 0;
    logic [1:0] mon_idx = 2'd0;
    logic       mon_fe = 1'b0;
    always @(posedge clk) begin
        #1;
        if (digit_strobe) begin
            mon_strobes++;
            mon_idx = digit_idx;
        end
        if (seg_err) mon_segerr++;
        if (frame_valid) begin
            mon_fv++;
            mon_fe = frame_err;
        end
    end

    // Reference state: pending digits of the current frame and last published frame.
    logic [3:0] sh_val [4];
    logic       sh_dot [4];
    logic [3:0] out_val [4];
    logic       out_dot [4];
    logic [3:0] pend;
    logic       pend_err;
    logic [1:0] last_idx;

    function automatic int decode(input logic [6:0] seg);
        for (int i = 0; i < 16; i++)
            if (seg_tab[i] == seg) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_val[i] = 4'h0; sh_dot[i] = 1'b0; out_val[i] = 4'h0; out_dot[i] = 1'b0;
        end
        pend = 4'h0; pend_err = 1'b0; last_idx = 2'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {an3, an2, an1, an0} = an;
            {ca, cb, cc, cd, ce, cf, cg} = seg;
            dp = d;
        end
    endtask

    // One dwell of n cycles followed by a blank gap long enough to flush the pipeline.
    task automatic dwell(input string tag, input logic [3:0] an, input logic [6:0] seg,
                         input logic d, input int n);
        int s0, e0, f0, code, k;
        logic cap, exp_fv, exp_fe;
        s0 = mon_strobes; e0 = mon_segerr; f0 = mon_fv;
        drive(an, seg, d, n);
        drive(4'hF, 7'h7F, 1'b1, 8);
        cap = ($countones(~an) == 1) && (n >= STABLE + 1);
        code = decode(seg);
        exp_fv = 1'b0; exp_fe = 1'b0;
        if (cap) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) k = i;
            last_idx = 2'(k);
            pend[k] = 1'b1;
            sh_dot[k] = ~d;
            if (code >= 0) sh_val[k] = 4'(code);
            else pend_err = 1'b1;
            if (pend == 4'hF) begin
                exp_fv = 1'b1; exp_fe = pend_err;
                for (int i = 0; i < 4; i++) begin
                    out_val[i] = sh_val[i]; out_dot[i] = sh_dot[i];
                end
                pend = 4'h0; pend_err = 1'b0;
            end
        end
        chk({tag, ".strobes"}, mon_strobes - s0, cap ? 1 : 0);
        chk({tag, ".seg_err"}, mon_segerr - e0, (cap && code < 0) ? 1 : 0);
        chk({tag, ".frame_valid"}, mon_fv - f0, exp_fv ? 1 : 0);
        if (exp_fv) chk({tag, ".frame_err"}, mon_fe, exp_fe);
        if (cap) chk({tag, ".strobe_idx"}, mon_idx, last_idx);
        chk({tag, ".digit_idx"}, digit_idx, last_idx);
        chk({tag, ".outputs"}, {val3, val2, val1, val0, dot3, dot2, dot1, dot0},
            {out_val[3], out_val[2], out_val[1], out_val[0],
             out_dot[3], out_dot[2], out_dot[1], out_dot[0]});
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {val3, val2, val1, val0, dot3, dot2, dot1, dot0,
                  digit_strobe, digit_idx, seg_err, frame_valid, frame_err}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] an;
        logic [6:0] seg;
        int r;
        rst = 1'b1;
        {an3, an2, an1, an0} = 4'hF;
        {ca, cb, cc, cd, ce, cf, cg} = 7'h7F;
        dp = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Basic frame 1,2,3,4 on digits 0..3.
        dwell("d0", 4'b1110, seg_tab[1], 1'b1, 20);
        dwell("d1", 4'b1101, seg_tab[2], 1'b1, 20);
        dwell("d2", 4'b1011, seg_tab[3], 1'b1, 20);
        dwell("d3", 4'b0111, seg_tab[4], 1'b1, 20);
        chk("frame1.vals", {val3, val2, val1, val0}, 16'h4321);

        dwell("short", 4'b1101, seg_tab[7], 1'b1, 3);
        dwell("edge5", 4'b1110, seg_tab[5], 1'b1, STABLE + 1);
        dwell("edge4", 4'b1101, seg_tab[6], 1'b1, STABLE);
        dwell("dual", 4'b1100, seg_tab[8], 1'b1, 50);

        // Bad pattern on digit 2 inside a frame: value keeps 3 from the previous frame.
        dwell("e1", 4'b1101, seg_tab[9], 1'b1, 20);
        dwell("e2bad", 4'b1011, 7'b1111111, 1'b1, 20);
        dwell("e3", 4'b0111, seg_tab[0], 1'b1, 20);
        chk("err.val2", val2, 4'h3);

        // Pattern A with the dot lit on digit 1, with a recapture of digit 0.
        dwell("a0", 4'b1110, seg_tab[2], 1'b0, 20);
        dwell("a0re", 4'b1110, seg_tab[12], 1'b1, 20);
        dwell("a1", 4'b1101, seg_tab[10], 1'b0, 20);
        dwell("a2", 4'b1011, seg_tab[14], 1'b1, 20);
        dwell("a3", 4'b0111, seg_tab[15], 1'b1, 20);
        chk("dotA", {val1, dot1}, {4'hA, 1'b1});

        // Reset mid-frame.
        dwell("r0", 4'b1110, seg_tab[7], 1'b1, 20);
        dwell("r1", 4'b1101, seg_tab[8], 1'b0, 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        dwell("n0", 4'b1110, seg_tab[11], 1'b1, 20);
        dwell("n1", 4'b1101, seg_tab[13], 1'b1, 20);
        dwell("n2", 4'b1011, seg_tab[6], 1'b0, 20);
        dwell("n3", 4'b0111, seg_tab[9], 1'b1, 20);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) an = 4'hF;
            else if (r == 1) an = ~(4'b0011 << $urandom_range(0, 2));
            else an = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
            else seg = seg_tab[$urandom_range(0, 15)];
            dwell($sformatf("rnd%0d", t), an, seg, 1'($urandom), $urandom_range(2, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
